// File: rtl/ps2_kbd_port.sv
// Purpose : PS/2 keyboard receiver; deframes 11-bit frames, checks odd parity, buffers scan codes for CPU polling.
// Latency : fall pulse 2+FILTER_LEN clk after the physical ps2_clk edge; byte pushed on the stop-bit fall, ready the cycle after.
// Backpr. : none toward the keyboard; a byte arriving while the FIFO is full (and not popped that cycle) is dropped and ovf is set.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ps2_clk, ps2_data raw keyboard lines (asynchronous)
//   rd                one-cycle read strobe from the address decoder (lw at 0xA000_0000)
//   dout              {22'b0, ovf, ready, byte[7:0]}, combinational from FIFO head and flags
//   ready             FIFO non-empty, mirrors dout[8]
`timescale 1ns/1ps
module ps2_kbd_port #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd,
    output logic [31:0] dout,
    output logic        ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] DEPTH_L  = PW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizers, glitch filter on ps2_clk
    // ------------------------------------------------------------------
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            filt   <= 1'b1;
            fcnt   <= '0;
            fall   <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FLT_LAST) begin
                // FILTER_LEN consecutive samples at the new level: accept it.
                filt <= clk_s2;
                fcnt <= '0;
                fall <= ~clk_s2;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Deframer FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t        state, state_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [8:0]    shreg, shreg_n;      // {parity, data[7:0]} once 9 bits are in
    logic [TW-1:0] tcnt, tcnt_n;
    logic          push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        tcnt_n   = tcnt;
        push     = 1'b0;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (fall && !dat_s2) begin
                    state_n  = SHIFT;
                    bitcnt_n = '0;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shreg_n = {dat_s2, shreg[8:1]};   // LSB first
                    tcnt_n  = '0;
                    if (bitcnt == 4'd8) state_n = CHECK;
                    else                bitcnt_n = bitcnt + 4'd1;
                end else if (tcnt == TO_LAST) begin
                    state_n  = IDLE;
                    tcnt_n   = '0;
                    bitcnt_n = '0;
                    shreg_n  = '0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            CHECK: begin
                if (fall) begin
                    // Stop bit must be 1 and data+parity must have odd weight.
                    push     = dat_s2 & (^shreg);
                    state_n  = IDLE;
                    tcnt_n   = '0;
                    bitcnt_n = '0;
                end else if (tcnt == TO_LAST) begin
                    state_n  = IDLE;
                    tcnt_n   = '0;
                    bitcnt_n = '0;
                    shreg_n  = '0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr, cnt;
    logic          ovf, full, pop, wr, drop;
    logic [7:0]    head;

    assign ready = (cnt != '0);
    assign full  = (cnt == DEPTH_L);
    assign pop   = rd & ready;
    // A simultaneous pop frees the slot the push lands in, so full does not block it.
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign head  = ready ? mem[rptr[AW-1:0]] : 8'h00;
    assign dout  = {22'd0, ovf, ready, head};

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= shreg[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr)  wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (pop) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop)    ovf <= 1'b1;
            else if (rd) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_port.sv
`timescale 1ns/1ps
module tb_ps2_kbd_port;

    localparam int H = 20;   // ps2_clk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd = 1'b0;
    logic [31:0] dout;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_kbd_port #(
        .FIFO_DEPTH    (8),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rd      (rd),
        .dout    (dout),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d, input logic pflip, input logic stop);
        return {stop, (~^d) ^ pflip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            cyc(H);
            ps2_clk = 1'b0;
            cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        send_bits(mkframe(d, 1'b0, 1'b1), 11);
        cyc(2 * H);
    endtask

    task automatic peek(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check(tag, dout, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check(tag, dout, exp);
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    initial begin
        // Reset
        cyc(3);
        peek("rst_dout", 32'h0);
        rst = 1'b0;
        cyc(2);
        peek("rst_dout_after", 32'h0);
        check("rst_ready", {31'd0, ready}, 32'd0);

        // 1. Basic frame
        send(8'h1C);
        peek("basic_dout", 32'h0000_011C);
        check("basic_ready", {31'd0, ready}, 32'd1);
        rd_chk("basic_rd", 32'h0000_011C);
        peek("basic_empty", 32'h0);

        // 2. Make/break sequence
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        rd_chk("mb_0", 32'h11C);
        rd_chk("mb_1", 32'h1F0);
        rd_chk("mb_2", 32'h11C);
        peek("mb_empty", 32'h0);

        // 3. Parity and framing errors
        send_bits(mkframe(8'h1C, 1'b1, 1'b1), 11);
        cyc(2 * H);
        peek("par_err", 32'h0);
        send_bits(mkframe(8'h1C, 1'b0, 1'b0), 11);
        cyc(2 * H);
        peek("stop_err", 32'h0);
        send(8'h32);
        peek("after_err", 32'h132);
        rd_chk("after_err_rd", 32'h132);

        // 4. Overflow
        for (int i = 1; i <= 9; i++) send(8'(i));
        peek("ovf_dout", 32'h0000_0301);
        rd_chk("ovf_rd1", 32'h301);
        for (int i = 2; i <= 8; i++) rd_chk("ovf_drain", 32'h100 | 32'(i));
        peek("ovf_empty", 32'h0);

        // 5. Glitch, then timeout
        ps2_data = 1'b0;
        cyc(H);
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(H);
        ps2_data = 1'b1;
        send(8'h2A);
        peek("glitch", 32'h12A);
        rd_chk("glitch_rd", 32'h12A);
        send_bits(mkframe(8'hA7, 1'b0, 1'b1), 5);
        cyc(300);
        send(8'h45);
        peek("timeout", 32'h145);
        rd_chk("timeout_rd", 32'h145);
        peek("timeout_empty", 32'h0);

        // 6a. Push and pop on the same edge with the FIFO full
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        peek("full_head", 32'h110);
        send_bits(mkframe(8'h18, 1'b0, 1'b1), 10);
        ps2_data = 1'b1;
        cyc(H);
        ps2_clk = 1'b0;
        cyc(6);            // fall is high in this cycle
        rd = 1'b1;
        check("sp_head", dout, 32'h110);
        cyc(1);
        rd = 1'b0;
        cyc(H - 7);
        ps2_clk = 1'b1;
        cyc(2 * H);
        peek("sp_after", 32'h111);
        for (int i = 1; i <= 8; i++) rd_chk("sp_drain", 32'h110 | 32'(i));
        peek("sp_empty", 32'h0);

        // 6b. Reset mid-frame with data buffered
        send(8'h21);
        peek("pre_rst", 32'h121);
        send_bits(mkframe(8'h33, 1'b0, 1'b1), 5);
        rst = 1'b1;
        cyc(2);
        peek("mid_rst", 32'h0);
        rst = 1'b0;
        cyc(2);
        peek("post_rst", 32'h0);
        check("post_rst_ready", {31'd0, ready}, 32'd0);
        send(8'h5A);
        peek("post_rst_frame", 32'h15A);
        rd_chk("post_rst_rd", 32'h15A);
        peek("final_empty", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
